// File: rtl/min_max_finder_param_pkg.sv
// Shared definitions for the min/max finder: one-hot state encoding and
// the address / length width derivations used by the top and the bench.
package min_max_finder_param_pkg;

    localparam int STATE_W = 4;
    typedef logic [STATE_W-1:0] state_t;

    localparam state_t STATE_INI  = 4'b0001;
    localparam state_t STATE_LOAD = 4'b0010;
    localparam state_t STATE_CMP  = 4'b0100;
    localparam state_t STATE_DONE = 4'b1000;

    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Len must be able to express DEPTH itself, hence depth+1.
    function automatic int len_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/min_max_finder_param_cmp_unit.sv
// Combinational strict compare of one element against the running max/min,
// signed or unsigned by parameter.
module min_max_cmp_unit #(
    parameter int WIDTH  = 8,
    parameter bit SIGNED = 1'b0
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] cur_max,
    input  logic [WIDTH-1:0] cur_min,
    output logic             gt_max,
    output logic             lt_min
);

    generate
        if (SIGNED) begin : g_signed
            assign gt_max = $signed(x) > $signed(cur_max);
            assign lt_min = $signed(x) < $signed(cur_min);
        end else begin : g_unsigned
            assign gt_max = x > cur_max;
            assign lt_min = x < cur_min;
        end
    endgenerate

endmodule

// File: rtl/min_max_finder_param.sv
// Register-array min/max finder: load through a write port, scan the first
// Len entries one per clock, hold results under a Done/Ack handshake.
module min_max_finder_param
    import min_max_finder_param_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 16,
    parameter bit SIGNED = 1'b0,
    localparam int AW    = addr_w(DEPTH),
    localparam int LW    = len_w(DEPTH)
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Wr_en,
    input  logic [AW-1:0]    Wr_addr,
    input  logic [WIDTH-1:0] Wr_data,
    input  logic             Start,
    input  logic [LW-1:0]    Len,
    input  logic             Ack,
    output logic [WIDTH-1:0] Max,
    output logic [WIDTH-1:0] Min,
    output logic [AW-1:0]    Max_idx,
    output logic [AW-1:0]    Min_idx,
    output logic             Empty,
    output logic             Qi,
    output logic             Ql,
    output logic             Qc,
    output logic             Qd
);

    logic [WIDTH-1:0] mem [DEPTH];

    state_t           state_reg, state_next;
    logic [AW-1:0]    i_reg;
    logic [LW-1:0]    len_r_reg;
    logic [WIDTH-1:0] max_reg, min_reg;
    logic [AW-1:0]    max_idx_reg, min_idx_reg;
    logic             empty_reg;

    logic [WIDTH-1:0] cur_x;
    logic             gt_max, lt_min;
    logic             addr_ok;
    logic             last_elem;

    // Out-of-range addresses can only exist when DEPTH is not a power of two.
    generate
        if (DEPTH == (1 << AW)) begin : g_addr_full
            assign addr_ok = 1'b1;
        end else begin : g_addr_chk
            assign addr_ok = Wr_addr < AW'(DEPTH);
        end
    endgenerate

    // Array is intentionally not reset so contents survive a Reset.
    always_ff @(posedge Clk) begin
        if (Wr_en && addr_ok && (state_reg == STATE_INI)) begin
            mem[Wr_addr] <= Wr_data;
        end
    end

    assign cur_x     = mem[i_reg];
    assign last_elem = (LW'(i_reg) == (len_r_reg - 1'b1));

    min_max_cmp_unit #(
        .WIDTH  (WIDTH),
        .SIGNED (SIGNED)
    ) u_cmp (
        .x       (cur_x),
        .cur_max (max_reg),
        .cur_min (min_reg),
        .gt_max  (gt_max),
        .lt_min  (lt_min)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_reg <= STATE_INI;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            STATE_INI:  if (Start) state_next = (Len == '0) ? STATE_DONE : STATE_LOAD;
            STATE_LOAD: state_next = (len_r_reg == LW'(1)) ? STATE_DONE : STATE_CMP;
            STATE_CMP:  if (last_elem) state_next = STATE_DONE;
            STATE_DONE: if (Ack) state_next = STATE_INI;
            default:    state_next = STATE_INI;
        endcase
    end

    always_comb begin
        Qi = state_reg[0];
        Ql = state_reg[1];
        Qc = state_reg[2];
        Qd = state_reg[3];
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            i_reg       <= '0;
            len_r_reg   <= '0;
            max_reg     <= '0;
            min_reg     <= '0;
            max_idx_reg <= '0;
            min_idx_reg <= '0;
            empty_reg   <= 1'b0;
        end else begin
            case (state_reg)
                STATE_INI: begin
                    if (Start) begin
                        len_r_reg <= (Len > LW'(DEPTH)) ? LW'(DEPTH) : Len;
                        i_reg     <= '0;
                        empty_reg <= (Len == '0);
                    end
                end
                STATE_LOAD: begin
                    max_reg     <= mem[0];
                    min_reg     <= mem[0];
                    max_idx_reg <= '0;
                    min_idx_reg <= '0;
                    i_reg       <= AW'(1);
                end
                STATE_CMP: begin
                    if (gt_max) begin
                        max_reg     <= cur_x;
                        max_idx_reg <= i_reg;
                    end
                    if (lt_min) begin
                        min_reg     <= cur_x;
                        min_idx_reg <= i_reg;
                    end
                    i_reg <= i_reg + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign Max     = max_reg;
    assign Min     = min_reg;
    assign Max_idx = max_idx_reg;
    assign Min_idx = min_idx_reg;
    assign Empty   = empty_reg;

endmodule
